// File: rtl/out_port_arbiter_pkg.sv
// Shared constants for the 5-input output-port arbiter: port indices,
// mux select codes and the arbiter state type.
package out_port_arbiter_pkg;

    localparam int NUM_PORTS = 5;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 3;
    localparam int P4 = 4;

    localparam logic [2:0] SEL_P0 = 3'b000;
    localparam logic [2:0] SEL_P1 = 3'b001;
    localparam logic [2:0] SEL_P2 = 3'b010;
    localparam logic [2:0] SEL_P3 = 3'b011;
    localparam logic [2:0] SEL_P4 = 3'b100;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Idle (all-zero) grant maps to port 0's code; out_valid qualifies it.
    function automatic logic [2:0] grant_to_sel(input logic [NUM_PORTS-1:0] g);
        logic [2:0] s;
        s = SEL_P0;
        case (g)
            5'b00001: s = SEL_P0;
            5'b00010: s = SEL_P1;
            5'b00100: s = SEL_P2;
            5'b01000: s = SEL_P3;
            5'b10000: s = SEL_P4;
            default:  s = SEL_P0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/out_port_arbiter_credit_counter.sv
// Downstream credit tracker: one credit consumed per transfer, one returned
// per credit pulse, saturating at CREDITS with a sticky overflow flag.
module credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec,
    input  logic       inc,
    output logic [3:0] count,
    output logic       err
);

    // dec is only raised while count != 0, so no underflow guard is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'(CREDITS);
            err   <= 1'b0;
        end else if (dec && !inc) begin
            count <= count - 4'd1;
        end else if (inc && !dec) begin
            if (count == 4'(CREDITS)) begin
                err <= 1'b1;
            end else begin
                count <= count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Round-robin, packet-locked arbiter for one router output port; drives the
// select code for the existing 5:1 flit mux and tracks downstream credits.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic [4:0] tail,
    input  logic       credit_in,
    output logic [4:0] grant,
    output logic [2:0] sel,
    output logic       out_valid,
    output logic [3:0] credit_cnt,
    output logic       cr_err
);

    arb_state_t state, state_nxt;
    logic [4:0] grant_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] winner_idx;
    logic       winner_found;
    logic [3:0] cand;
    logic [2:0] owner_idx;
    logic       tail_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= 3'(P0);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // First requester at or after ptr, wrapping past port 4 back to port 0.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = ptr;
        cand         = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'(NUM_PORTS)) begin
                cand = cand - 4'(NUM_PORTS);
            end
            if (!winner_found && req[cand[2:0]]) begin
                winner_found = 1'b1;
                winner_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        owner_idx = 3'(P0);
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                owner_idx = 3'(i);
            end
        end
    end

    assign out_valid = (state == LOCKED) && ((grant & req) != 5'b0) && (credit_cnt != 4'd0);
    assign tail_xfer = out_valid && ((grant & tail) != 5'b0);
    assign sel       = grant_to_sel(grant);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (winner_found && (credit_cnt != 4'd0)) begin
                    state_nxt = LOCKED;
                    grant_nxt = 5'b00001 << winner_idx;
                end
            end
            LOCKED: begin
                if (tail_xfer) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = (owner_idx == 3'(P4)) ? 3'(P0) : owner_idx + 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    credit_counter #(
        .CREDITS(CREDITS)
    ) u_credit_counter (
        .clk  (clk),
        .reset(reset),
        .dec  (out_valid),
        .inc  (credit_in),
        .count(credit_cnt),
        .err  (cr_err)
    );

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: an owner/pointer/credit model checks
// every cycle, and literal expectations pin the key scenarios.
module tb_out_port_arbiter;

    localparam int CREDITS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] req;
    logic [4:0] tail;
    logic       credit_in;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       out_valid;
    logic [3:0] credit_cnt;
    logic       cr_err;

    int errors = 0;
    int checks = 0;

    int m_owner   = -1;
    int m_ptr     = 0;
    int m_credits = 0;
    bit m_err     = 1'b0;
    bit m_live    = 1'b0;
    bit exp_ov;

    always #5 clk = ~clk;

    out_port_arbiter #(
        .CREDITS(CREDITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .tail      (tail),
        .credit_in (credit_in),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .credit_cnt(credit_cnt),
        .cr_err    (cr_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One cycle of inputs; returns at the following falling edge.
    task automatic applyStimulus(input logic r, input logic [4:0] q, input logic [4:0] t, input logic c);
        @(posedge clk);
        #1;
        reset     = r;
        req       = q;
        tail      = t;
        credit_in = c;
        @(negedge clk);
    endtask

    // Model: owner port number (-1 idle), next-search pointer, credit count.
    always @(negedge clk) begin
        exp_ov = (m_owner >= 0) && req[m_owner] && (m_credits > 0);
        if (m_live) begin
            checkOutput("model_grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            checkOutput("model_sel", 32'(sel), (m_owner < 0) ? 32'd0 : 32'(m_owner));
            checkOutput("model_out_valid", 32'(out_valid), 32'(exp_ov));
            checkOutput("model_credit_cnt", 32'(credit_cnt), 32'(m_credits));
            checkOutput("model_cr_err", 32'(cr_err), 32'(m_err));
        end
        if (reset === 1'b1) begin
            m_owner   = -1;
            m_ptr     = 0;
            m_credits = CREDITS;
            m_err     = 1'b0;
            m_live    = 1'b1;
        end else if (m_live) begin
            if (m_owner < 0) begin
                if (req != 5'b0 && m_credits > 0) begin
                    for (int i = 0; i < 5; i++) begin
                        if (m_owner < 0 && req[(m_ptr + i) % 5]) begin
                            m_owner = (m_ptr + i) % 5;
                        end
                    end
                end
            end else if (exp_ov && tail[m_owner]) begin
                m_ptr   = (m_owner + 1) % 5;
                m_owner = -1;
            end
            if (exp_ov && !credit_in) begin
                m_credits = m_credits - 1;
            end else if (credit_in && !exp_ov) begin
                if (m_credits == CREDITS) m_err = 1'b1;
                else m_credits = m_credits + 1;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req       = 5'b0;
        tail      = 5'b0;
        credit_in = 1'b0;

        // Reset values, then lowest-index win from ptr 0 and ptr advance.
        applyStimulus(1, 5'b00000, 5'b00000, 0);
        applyStimulus(1, 5'b00000, 5'b00000, 0);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_sel", 32'(sel), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_credit_cnt", 32'(credit_cnt), 32'd4);
        checkOutput("rst_cr_err", 32'(cr_err), 32'd0);
        applyStimulus(0, 5'b00101, 5'b00000, 0);
        checkOutput("arb_latency_ov", 32'(out_valid), 32'd0);
        applyStimulus(0, 5'b00101, 5'b00001, 0);
        checkOutput("first_grant", 32'(grant), 32'b00001);
        checkOutput("first_sel", 32'(sel), 32'd0);
        checkOutput("first_ov", 32'(out_valid), 32'd1);
        applyStimulus(0, 5'b00101, 5'b00101, 0);
        checkOutput("after_tail_credit", 32'(credit_cnt), 32'd3);
        applyStimulus(0, 5'b00000, 5'b00000, 0);
        checkOutput("ptr1_grant", 32'(grant), 32'b00100);
        applyStimulus(0, 5'b00100, 5'b00100, 1);

        // All ports requesting single-flit packets with credits returned.
        applyStimulus(1, 5'b00000, 5'b00000, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 5'b11111, 5'b11111, 0);
            checkOutput("rr_idle_ov", 32'(out_valid), 32'd0);
            applyStimulus(0, 5'b11111, 5'b11111, 1);
            checkOutput("rr_grant", 32'(grant), 32'd1 << (k % 5));
            checkOutput("rr_ov", 32'(out_valid), 32'd1);
            if (k == 4) checkOutput("rr_sel_p4", 32'(sel), 32'b100);
        end

        // Port 2 three-flit packet with a one-cycle stall; port 3 waits.
        applyStimulus(1, 5'b00000, 5'b00000, 0);
        applyStimulus(0, 5'b01100, 5'b00000, 0);
        applyStimulus(0, 5'b01100, 5'b00000, 0);
        checkOutput("p2_flit1", 32'(grant), 32'b00100);
        applyStimulus(0, 5'b01000, 5'b00000, 0);
        checkOutput("p2_stall_ov", 32'(out_valid), 32'd0);
        checkOutput("p2_stall_grant", 32'(grant), 32'b00100);
        applyStimulus(0, 5'b01100, 5'b00000, 0);
        applyStimulus(0, 5'b01100, 5'b00100, 0);
        checkOutput("p2_tail_ov", 32'(out_valid), 32'd1);
        applyStimulus(0, 5'b01000, 5'b00000, 0);
        checkOutput("p3_wait_grant", 32'(grant), 32'd0);
        applyStimulus(0, 5'b01000, 5'b01000, 0);
        checkOutput("p3_grant", 32'(grant), 32'b01000);
        checkOutput("p3_credit", 32'(credit_cnt), 32'd1);

        // Credit exhaustion on a long packet, then a single returned credit.
        applyStimulus(1, 5'b00000, 5'b00000, 0);
        applyStimulus(0, 5'b00001, 5'b00000, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 5'b00001, 5'b00000, 0);
            checkOutput("drain_ov", 32'(out_valid), 32'd1);
        end
        applyStimulus(0, 5'b00001, 5'b00000, 0);
        checkOutput("empty_ov", 32'(out_valid), 32'd0);
        checkOutput("empty_credit", 32'(credit_cnt), 32'd0);
        applyStimulus(0, 5'b00001, 5'b00000, 1);
        applyStimulus(0, 5'b00001, 5'b00000, 0);
        checkOutput("one_credit_ov", 32'(out_valid), 32'd1);
        applyStimulus(0, 5'b00001, 5'b00000, 0);
        checkOutput("again_empty_ov", 32'(out_valid), 32'd0);

        // Simultaneous consume/return, then overflow at full credit.
        applyStimulus(0, 5'b00000, 5'b00000, 1);
        applyStimulus(0, 5'b00000, 5'b00000, 1);
        applyStimulus(0, 5'b00001, 5'b00000, 1);
        checkOutput("both_ov", 32'(out_valid), 32'd1);
        checkOutput("both_pre_credit", 32'(credit_cnt), 32'd2);
        applyStimulus(0, 5'b00000, 5'b00000, 0);
        checkOutput("both_post_credit", 32'(credit_cnt), 32'd2);
        applyStimulus(0, 5'b00000, 5'b00000, 1);
        applyStimulus(0, 5'b00000, 5'b00000, 1);
        applyStimulus(0, 5'b00000, 5'b00000, 1);
        applyStimulus(0, 5'b00000, 5'b00000, 0);
        checkOutput("ovf_credit", 32'(credit_cnt), 32'd4);
        checkOutput("ovf_err", 32'(cr_err), 32'd1);
        applyStimulus(0, 5'b00000, 5'b00000, 0);
        checkOutput("ovf_err_sticky", 32'(cr_err), 32'd1);

        // Reset in the middle of a packet locked on port 1.
        applyStimulus(0, 5'b00001, 5'b00001, 0);
        applyStimulus(0, 5'b00010, 5'b00000, 0);
        applyStimulus(0, 5'b00010, 5'b00000, 0);
        applyStimulus(0, 5'b00010, 5'b00000, 0);
        applyStimulus(0, 5'b00000, 5'b00000, 0);
        checkOutput("mid_grant", 32'(grant), 32'b00010);
        checkOutput("mid_credit", 32'(credit_cnt), 32'd1);
        applyStimulus(1, 5'b00010, 5'b00000, 1);
        applyStimulus(0, 5'b00011, 5'b00000, 0);
        checkOutput("mrst_grant", 32'(grant), 32'd0);
        checkOutput("mrst_credit", 32'(credit_cnt), 32'd4);
        checkOutput("mrst_err", 32'(cr_err), 32'd0);
        checkOutput("mrst_sel", 32'(sel), 32'd0);
        applyStimulus(0, 5'b00000, 5'b00000, 0);
        checkOutput("mrst_ptr0_grant", 32'(grant), 32'b00001);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
